router_pkt_framer: RTL and testbench

- Upstream source stage for the 1x3 router.
- Accepts a packet request (destination address, payload length) and its payload bytes from a host-side valid/ready interface, and stores the whole payload internally.
- Then drives the router input (din, pkt_valid) as one contiguous packet: header, payload, parity. Stalls on router busy.
- Store-and-forward is mandatory: the router treats pkt_valid low as end-of-packet, so the payload cannot have gaps.

---
 rtl/router_pkt_framer_if.sv | 30 +++
 rtl/router_pkt_framer.sv | 129 ++++++++++++
 tb/tb_router_pkt_framer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_framer_if.sv
// Host-to-framer-to-router signal bundle for the 1x3 router source stage.
// req_*/pay_* are valid/ready: a beat transfers at a rising edge with valid && ready; busy stalls din.
interface router_pkt_framer_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_addr;
    logic [5:0]       req_len;
    logic             req_bad_parity;
    logic             req_err;
    logic             pay_valid;
    logic [7:0]       pay_data;
    logic             pay_ready;
    logic             busy;
    logic [7:0]       din;
    logic             pkt_valid;
    logic             pkt_done;
    logic [CNT_W-1:0] pkt_count;

    modport master (
        output req_valid, req_addr, req_len, req_bad_parity, pay_valid, pay_data, busy,
        input  req_ready, req_err, pay_ready, din, pkt_valid, pkt_done, pkt_count
    );

    modport slave (
        input  req_valid, req_addr, req_len, req_bad_parity, pay_valid, pay_data, busy,
        output req_ready, req_err, pay_ready, din, pkt_valid, pkt_done, pkt_count
    );
endinterface

// File: rtl/router_pkt_framer.sv
// Store-and-forward packet framer: buffers a whole payload, then streams
// header, payload and parity to the router as one gap-free packet.
module router_pkt_framer #(
    parameter int MAX_LEN = 63,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    router_pkt_framer_if.slave  io,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       addr_q;
    logic [5:0]       len_q;
    logic             bad_q;
    logic [7:0]       parity;
    logic [5:0]       wr_idx;
    logic [5:0]       rd_idx;
    logic [7:0]       din_q;
    logic             pkt_valid_q;
    logic             req_err_q;
    logic             pkt_done_q;
    logic [CNT_W-1:0] cnt_q;
    logic             len_too_long;

    logic [7:0] pay_buf [MAX_LEN];

    assign len_too_long = (int'(io.req_len) > MAX_LEN);

    assign io.req_ready = (state == IDLE);
    assign io.pay_ready = (state == COLLECT);
    assign io.din       = din_q;
    assign io.pkt_valid = pkt_valid_q;
    assign io.req_err   = req_err_q;
    assign io.pkt_done  = pkt_done_q;
    assign io.pkt_count = cnt_q;
    assign dbg_state    = state;

    // Payload storage carries no reset; only bytes written this packet are read.
    always_ff @(posedge clk) begin
        if (state == COLLECT && io.pay_valid) begin
            pay_buf[wr_idx] <= io.pay_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            bad_q       <= 1'b0;
            parity      <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            din_q       <= '0;
            pkt_valid_q <= 1'b0;
            req_err_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            req_err_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.req_valid) begin
                        if (io.req_addr == 2'd3 || io.req_len == 6'd0 || len_too_long) begin
                            req_err_q <= 1'b1;
                        end else begin
                            addr_q <= io.req_addr;
                            len_q  <= io.req_len;
                            bad_q  <= io.req_bad_parity;
                            parity <= {io.req_len, io.req_addr};
                            wr_idx <= '0;
                            state  <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (io.pay_valid) begin
                        parity <= parity ^ io.pay_data;
                        wr_idx <= wr_idx + 6'd1;
                        // Header goes out the cycle after the final payload byte lands.
                        if (wr_idx == len_q - 6'd1) begin
                            din_q       <= {len_q, addr_q};
                            pkt_valid_q <= 1'b1;
                            state       <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (!io.busy) begin
                        din_q  <= pay_buf[0];
                        rd_idx <= 6'd1;
                        state  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!io.busy) begin
                        if (rd_idx == len_q) begin
                            din_q       <= bad_q ? ~parity : parity;
                            pkt_valid_q <= 1'b0;
                            state       <= PARITY;
                        end else begin
                            din_q  <= pay_buf[rd_idx];
                            rd_idx <= rd_idx + 6'd1;
                        end
                    end
                end
                PARITY: begin
                    if (!io.busy) begin
                        din_q      <= '0;
                        pkt_done_q <= 1'b1;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_pkt_framer.sv
// Directed bench for router_pkt_framer: expected router bytes and packet counts
// are queued by the stimulus and consumed by an independent monitor.
module tb_router_pkt_framer;
    localparam int MAX_LEN = 63;
    localparam int CNT_W   = 2;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd4;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] dbg_state;

    router_pkt_framer_if #(.CNT_W(CNT_W)) bus ();

    router_pkt_framer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .io        (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard state: {pkt_valid, din} per router transfer, and pkt_count per completion.
    logic [8:0]       exp_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];
    logic [CNT_W-1:0] exp_cnt;
    logic [7:0]       pay_q[$];
    bit               expect_done;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: a router transfer happens at each edge with busy low in HEADER..PARITY.
    always @(negedge clk) begin
        if (rstn) begin
            if (expect_done) begin
                check("pkt_done pulse", 32'(bus.pkt_done), 32'd1);
                if (exp_cnt_q.size() == 0) fail_now("pkt_count: no expected value queued");
                else check("pkt_count", 32'(bus.pkt_count), 32'(exp_cnt_q.pop_front()));
                expect_done = 1'b0;
            end else begin
                check("pkt_done idle", 32'(bus.pkt_done), 32'd0);
            end
            if (!bus.busy && dbg_state >= S_HEADER && dbg_state <= S_PARITY) begin
                if (exp_q.size() == 0) begin
                    fail_now("router byte: unexpected transfer");
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("router {pkt_valid,din}", 32'({bus.pkt_valid, bus.din}), 32'(e));
                    if (!e[8]) expect_done = 1'b1;
                end
            end
        end
    end

    task automatic push_byte(input logic pv, input logic [7:0] b);
        exp_q.push_back({pv, b});
    endtask

    task automatic push_done();
        exp_cnt = exp_cnt + CNT_W'(1);
        exp_cnt_q.push_back(exp_cnt);
    endtask

    task automatic send_req(input logic [1:0] a, input logic [5:0] l, input logic b);
        bus.req_valid      = 1'b1;
        bus.req_addr       = a;
        bus.req_len        = l;
        bus.req_bad_parity = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic send_payload(input int max_gap);
        while (pay_q.size() > 0) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.pay_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            bus.pay_valid = 1'b1;
            bus.pay_data  = pay_q.pop_front();
            @(posedge clk); #1;
        end
        bus.pay_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.pkt_done) seen = 1'b1;
        end
        if (!seen) fail_now("wait_done: pkt_done not seen within budget");
    endtask

    task automatic reset_checks();
        check("reset din",       32'(bus.din),       32'd0);
        check("reset pkt_valid", 32'(bus.pkt_valid), 32'd0);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset pay_ready", 32'(bus.pay_ready), 32'd0);
        check("reset pkt_count", 32'(bus.pkt_count), 32'd0);
        check("reset req_err",   32'(bus.req_err),   32'd0);
        check("reset state",     32'(dbg_state),     32'(S_IDLE));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        reset_checks();
        exp_q.delete();
        exp_cnt_q.delete();
        expect_done = 1'b0;
        exp_cnt     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] par;
        logic [7:0] hdr;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.req_bad_parity = 1'b0;
        bus.pay_valid = 1'b0; bus.pay_data = '0; bus.busy = 1'b0;
        exp_cnt = '0;
        expect_done = 1'b0;
        #3;
        reset_checks();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of collecting a payload.
        send_req(2'd0, 6'd3, 1'b0);
        check("collect pay_ready", 32'(bus.pay_ready), 32'd1);
        pay_q = '{8'h01};
        send_payload(0);
        do_reset();

        // addr 0, len 2, no stalls.
        push_byte(1'b1, 8'h08); push_byte(1'b1, 8'h11); push_byte(1'b1, 8'h22); push_byte(1'b0, 8'h3B);
        push_done();
        send_req(2'd0, 6'd2, 1'b0);
        pay_q = '{8'h11, 8'h22};
        send_payload(0);
        wait_done(20);

        // addr 1, len 4, header stalled two cycles; stray req/pay activity must be ignored.
        push_byte(1'b1, 8'h11); push_byte(1'b1, 8'hA1); push_byte(1'b1, 8'hB2);
        push_byte(1'b1, 8'hC3); push_byte(1'b1, 8'hD4); push_byte(1'b0, 8'h15);
        push_done();
        send_req(2'd1, 6'd4, 1'b0);
        bus.req_valid = 1'b1; bus.req_addr = 2'd3;
        pay_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_payload(1);
        check("req outside idle no err", 32'(bus.req_err), 32'd0);
        bus.req_valid = 1'b0;
        bus.busy = 1'b1;
        bus.pay_valid = 1'b1; bus.pay_data = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("busy hold din",       32'(bus.din),       32'h11);
            check("busy hold pkt_valid", 32'(bus.pkt_valid), 32'd1);
        end
        bus.busy = 1'b0;
        bus.pay_valid = 1'b0;
        wait_done(30);

        // Illegal requests.
        send_req(2'd3, 6'd2, 1'b0);
        check("addr3 req_err",   32'(bus.req_err),   32'd1);
        check("addr3 pay_ready", 32'(bus.pay_ready), 32'd0);
        @(posedge clk); #1;
        check("addr3 req_err single", 32'(bus.req_err), 32'd0);
        send_req(2'd0, 6'd0, 1'b0);
        check("len0 req_err",   32'(bus.req_err),   32'd1);
        check("len0 pay_ready", 32'(bus.pay_ready), 32'd0);
        @(posedge clk); #1;
        check("len0 req_err single", 32'(bus.req_err),   32'd0);
        check("len0 pkt_valid",      32'(bus.pkt_valid), 32'd0);
        check("illegal pkt_count",   32'(bus.pkt_count), 32'(exp_cnt));

        // len 1 with parity error injection.
        push_byte(1'b1, 8'h06); push_byte(1'b1, 8'hFF); push_byte(1'b0, 8'h06);
        push_done();
        send_req(2'd2, 6'd1, 1'b1);
        pay_q = '{8'hFF};
        send_payload(0);
        wait_done(20);

        // Full-length packet with gaps, reset while streaming the payload.
        hdr = {6'd63, 2'd2};
        push_byte(1'b1, hdr);
        for (int i = 0; i < MAX_LEN; i++) begin
            pay_q.push_back(8'(i * 7 + 3));
            push_byte(1'b1, 8'(i * 7 + 3));
        end
        send_req(2'd2, 6'd63, 1'b0);
        send_payload(2);
        repeat (5) begin @(posedge clk); #1; end
        do_reset();

        // Clean packet after the abandoned one.
        push_byte(1'b1, 8'h09); push_byte(1'b1, 8'h5A); push_byte(1'b1, 8'hA5); push_byte(1'b0, 8'hF6);
        push_done();
        send_req(2'd1, 6'd2, 1'b0);
        pay_q = '{8'h5A, 8'hA5};
        send_payload(0);
        wait_done(20);

        // Three more len-1 packets take the 2-bit counter through its wrap.
        for (int i = 0; i < 3; i++) begin
            hdr = {6'd1, 2'(i)};
            par = hdr ^ 8'(8'h30 + i);
            push_byte(1'b1, hdr); push_byte(1'b1, 8'(8'h30 + i)); push_byte(1'b0, par);
            push_done();
            send_req(2'(i), 6'd1, 1'b0);
            pay_q = '{8'(8'h30 + i)};
            send_payload(0);
            wait_done(20);
        end
        @(posedge clk); #1;
        check("pkt_count wrapped", 32'(bus.pkt_count), 32'd0);
        check("router bytes drained",  32'(exp_q.size()),     32'd0);
        check("pkt counts drained",    32'(exp_cnt_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
